// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO in front of an 8N1 serializer.
// The serial line is registered from the FSM state, so it lags the state by one clock.
module uart_tx #(
  parameter int CLOCK_RATE = 10000000,
  parameter int BAUD_RATE  = 625000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  if ((CLOCK_RATE % BAUD_RATE) != 0 || CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLOCK_RATE/BAUD_RATE must be an integer >= 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx: FIFO_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- byte FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic          push, pop, fifo_empty;

  assign tx_ready   = (count != NW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- serializer ----------------
  state_t        state, state_nxt;
  logic [CW-1:0] bit_cnt, bit_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg;
  logic          tx_nxt, bit_done;

  assign bit_done = (bit_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    pop         = 1'b0;
    tx_nxt      = 1'b1;
    if (state != IDLE) bit_cnt_nxt = bit_done ? '0 : bit_cnt + 1'b1;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (!fifo_empty) begin
          pop         = 1'b1;
          state_nxt   = START;
          bit_cnt_nxt = '0;
          bit_idx_nxt = '0;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (bit_done) state_nxt = DATA;
      end
      DATA: begin
        tx_nxt = shreg[bit_idx];
        if (bit_done) begin
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 1'b1;
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        // Chain straight into the next start bit when more bytes are queued.
        if (bit_done) begin
          if (!fifo_empty) begin
            pop         = 1'b1;
            state_nxt   = START;
            bit_idx_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      tx      <= tx_nxt;
      if (pop) shreg <= mem[rd_ptr];
    end
  end

  assign tx_busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: logs the line every cycle and compares it with frames
// built from the byte stream by plain 8N1 arithmetic.
module tb_uart_tx;
  localparam int NLOG = 16384;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data, f_tx_data;
  logic       tx_valid, f_tx_valid;
  logic       tx_ready, tx, tx_busy;
  logic       f_tx_ready, f_tx, f_tx_busy;

  uart_tx dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy));

  uart_tx #(.BAUD_RATE(2500000)) u_fast (
    .clk(clk), .rst_n(rst_n), .tx_data(f_tx_data), .tx_valid(f_tx_valid),
    .tx_ready(f_tx_ready), .tx(f_tx), .tx_busy(f_tx_busy));

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic tx_at [NLOG];
  logic busy_at [NLOG];
  logic rdy_at [NLOG];
  logic ftx_at [NLOG];
  logic fbusy_at [NLOG];

  always @(posedge clk) cyc <= cyc + 1;

  // Index n holds the value seen after rising edge n.
  always @(negedge clk) begin
    if (cyc < NLOG) begin
      tx_at[cyc]    <= tx;
      busy_at[cyc]  <= tx_busy;
      rdy_at[cyc]   <= tx_ready;
      ftx_at[cyc]   <= f_tx;
      fbusy_at[cyc] <= f_tx_busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Line level t clocks into a frame: start bit, 8 data bits LSB first, stop bit.
  function automatic logic exp_level(input logic [7:0] b, input int t, input int cpb);
    int n = t / cpb;
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
    return 1'b1;
  endfunction

  // First offset where the logged line departs from the frames of q followed by idle.
  function automatic int first_bad(input bit fast, input int start, input logic [7:0] q[$],
                                   input int idle_n, output logic got, output logic want);
    int cpb  = fast ? 4 : 16;
    int flen = 10 * cpb;
    int tot  = q.size() * flen;
    got = 1'b0; want = 1'b0;
    for (int t = 0; t < tot + idle_n; t++) begin
      if (start + t >= NLOG) return t;
      want = (t < tot) ? exp_level(q[t / flen], t % flen, cpb) : 1'b1;
      got  = fast ? ftx_at[start + t] : tx_at[start + t];
      if (got !== want) return t;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Hold tx_valid and present q in order; acc gets the accepting edge of each byte.
  task automatic stream(input logic [7:0] q[$], input bit keep, output int acc[$]);
    int n = 0;
    acc = {};
    tx_valid = 1'b1;
    tx_data  = q[0];
    for (int i = 0; i < 1000 && n < q.size(); i++) begin
      @(negedge clk);
      if (tx_ready) begin acc.push_back(cyc + 1); n++; end
      step();
      if (n < q.size()) tx_data = q[n];
    end
    if (!keep) begin tx_valid = 1'b0; tx_data = 8'($urandom); end
    if (n != q.size()) begin
      errors++;
      $display("FAIL stream_accept: got %0d bytes want %0d", n, q.size());
      while (acc.size() < q.size()) acc.push_back(cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; f_tx_valid = 1'b0; f_tx_data = 8'h00;
    repeat (3) step();
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    checks++; if (f_tx !== 1'b1)     begin errors++; $display("FAIL reset_fast_tx: got %b want 1", f_tx); end
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (tx !== 1'b1 || tx_busy !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset: got tx=%b busy=%b want tx=1 busy=0", tx, tx_busy); end
  endtask

  // One byte from idle; tx_data is scrambled every cycle after acceptance.
  task automatic test_single(input logic [7:0] b);
    int acc[$]; int k, p, bad; logic g, w;
    stream('{b}, 1'b0, acc);
    k = acc[0]; p = k + 1;
    repeat (175) begin tx_data = 8'($urandom); step(); end
    checks++; if (tx_at[p] !== 1'b1)
      begin errors++; $display("FAIL single_latency %h: got tx=%b at pop edge want 1", b, tx_at[p]); end
    bad = first_bad(1'b0, p + 1, '{b}, 8, g, w);
    checks++; if (bad != -1)
      begin errors++; $display("FAIL single_frame %h: got %b want %b at offset %0d", b, g, w, bad); end
    checks++; if (busy_at[k] !== 1'b1 || busy_at[p+159] !== 1'b1)
      begin errors++; $display("FAIL single_busy_hold %h: got %b/%b want 1/1", b, busy_at[k], busy_at[p+159]); end
    checks++; if (busy_at[p+160] !== 1'b0)
      begin errors++; $display("FAIL single_busy_fall %h: got %b want 0", b, busy_at[p+160]); end
  endtask

  task automatic test_back_to_back();
    int acc[$]; int bad; logic g, w;
    logic [7:0] q[$] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    stream(q, 1'b0, acc);
    for (int i = 1; i < 5; i++) begin
      checks++; if (acc[i] != acc[0] + i)
        begin errors++; $display("FAIL b2b_accept%0d: got edge %0d want %0d", i, acc[i], acc[0] + i); end
    end
    checks++; if (rdy_at[acc[0]+4] !== 1'b0 || rdy_at[acc[0]+160] !== 1'b0)
      begin errors++; $display("FAIL b2b_ready_low: got %b/%b want 0/0", rdy_at[acc[0]+4], rdy_at[acc[0]+160]); end
    checks++; if (acc[5] != acc[0] + 162)
      begin errors++; $display("FAIL b2b_accept5: got edge %0d want %0d", acc[5], acc[0] + 162); end
    repeat (6 * 160 + 20) step();
    bad = first_bad(1'b0, acc[0] + 2, q, 10, g, w);
    checks++; if (bad != -1)
      begin errors++; $display("FAIL b2b_frames: got %b want %b at offset %0d", g, w, bad); end
    checks++; if (busy_at[acc[0]+960] !== 1'b1 || busy_at[acc[0]+961] !== 1'b0)
      begin errors++; $display("FAIL b2b_busy: got %b/%b want 1/0", busy_at[acc[0]+960], busy_at[acc[0]+961]); end
  endtask

  // Fill the FIFO, then lean on tx_valid with 0xFF while it is full.
  task automatic test_full_ignore();
    int acc[$]; int bad; logic g, w; bit leak = 1'b0;
    logic [7:0] q[$];
    for (int i = 0; i < 5; i++) q.push_back(8'($urandom_range(0, 254)));
    stream(q, 1'b1, acc);
    tx_data = 8'hFF;
    repeat (100) begin
      @(negedge clk);
      if (tx_ready) leak = 1'b1;
      step();
    end
    tx_valid = 1'b0;
    checks++; if (leak)
      begin errors++; $display("FAIL full_ready: got ready=1 while full want 0"); end
    repeat (5 * 160 + 60) step();
    bad = first_bad(1'b0, acc[0] + 2, q, 40, g, w);
    checks++; if (bad != -1)
      begin errors++; $display("FAIL full_frames: got %b want %b at offset %0d", g, w, bad); end
    checks++; if (busy_at[acc[0]+801] !== 1'b0)
      begin errors++; $display("FAIL full_busy: got %b want 0", busy_at[acc[0]+801]); end
  endtask

  task automatic test_zero_ff();
    int acc[$]; int bad; logic g, w;
    stream('{8'h00, 8'hFF}, 1'b0, acc);
    checks++; if (acc[1] != acc[0] + 1)
      begin errors++; $display("FAIL zff_accept: got edge %0d want %0d", acc[1], acc[0] + 1); end
    repeat (360) step();
    bad = first_bad(1'b0, acc[0] + 2, '{8'h00, 8'hFF}, 30, g, w);
    checks++; if (bad != -1)
      begin errors++; $display("FAIL zff_frames: got %b want %b at offset %0d", g, w, bad); end
  endtask

  task automatic test_reset_midframe();
    int acc[$]; int p, rel, bad; logic g, w; bit bad_tx = 1'b0, bad_busy = 1'b0;
    logic [7:0] b;
    stream('{8'h3C, 8'($urandom), 8'($urandom)}, 1'b0, acc);
    p = acc[0] + 1;
    while (cyc < p + 73) step();
    #2;
    checks++; if (tx !== exp_level(8'h3C, 72, 16) || tx_busy !== 1'b1)
      begin errors++; $display("FAIL mid_prereset: got tx=%b busy=%b want tx=%b busy=1", tx, tx_busy, exp_level(8'h3C, 72, 16)); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL mid_reset_tx: got %b want 1", tx); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b want 1", tx_ready); end
    checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL mid_reset_busy: got %b want 0", tx_busy); end
    repeat (3) step();
    rst_n = 1'b1;
    rel = cyc;
    repeat (200) step();
    for (int i = rel; i < rel + 200; i++) begin
      if (tx_at[i] !== 1'b1) bad_tx = 1'b1;
      if (busy_at[i] !== 1'b0) bad_busy = 1'b1;
    end
    checks++; if (bad_tx)   begin errors++; $display("FAIL mid_no_frames: got tx low after release want idle 1"); end
    checks++; if (bad_busy) begin errors++; $display("FAIL mid_no_busy: got busy 1 after release want 0"); end
    b = 8'($urandom);
    stream('{b}, 1'b0, acc);
    repeat (175) step();
    checks++; if (tx_at[acc[0]+1] !== 1'b1 || tx_at[acc[0]+2] !== 1'b0)
      begin errors++; $display("FAIL mid_relatency: got %b%b want 10", tx_at[acc[0]+1], tx_at[acc[0]+2]); end
    bad = first_bad(1'b0, acc[0] + 2, '{b}, 8, g, w);
    checks++; if (bad != -1)
      begin errors++; $display("FAIL mid_new_frame: got %b want %b at offset %0d", g, w, bad); end
  endtask

  task automatic test_fast();
    int k = -1; int bad; logic g, w;
    f_tx_valid = 1'b1; f_tx_data = 8'h81;
    for (int i = 0; i < 50 && k < 0; i++) begin
      @(negedge clk);
      if (f_tx_ready) k = cyc + 1;
      step();
    end
    f_tx_valid = 1'b0; f_tx_data = 8'($urandom);
    checks++; if (k < 0) begin errors++; $display("FAIL fast_accept: got no accept want accept"); k = cyc; end
    repeat (50) step();
    bad = first_bad(1'b1, k + 2, '{8'h81}, 6, g, w);
    checks++; if (bad != -1)
      begin errors++; $display("FAIL fast_frame: got %b want %b at offset %0d", g, w, bad); end
    checks++; if (fbusy_at[k+40] !== 1'b1 || fbusy_at[k+41] !== 1'b0)
      begin errors++; $display("FAIL fast_busy: got %b/%b want 1/0", fbusy_at[k+40], fbusy_at[k+41]); end
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    repeat (3) test_single(8'($urandom));
    test_back_to_back();
    test_full_ignore();
    test_zero_ff();
    test_reset_midframe();
    test_fast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLOCK_RATE, default 10000000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 625000: serial bit rate in bit/s.
REQ-003 Parameter FIFO_DEPTH, default 4: transmit byte buffer depth; power of two, 2..16.
REQ-004 Local CLKS_PER_BIT SHALL equal CLOCK_RATE/BAUD_RATE, which is 16 at defaults; a non-integer ratio or a value below 2 SHALL be an elaboration error.
REQ-005 clk  input  1  single system clock, rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 tx_data  input  8  byte to transmit.
REQ-008 tx_valid  input  1  tx_data is valid.
REQ-009 tx_ready  output  1  block can accept a byte this cycle.
REQ-010 tx  output  1  serial line, registered, idle high.
REQ-011 tx_busy  output  1  frame in progress or FIFO non-empty.

Function
REQ-012 A byte SHALL be accepted on a rising edge where tx_valid and tx_ready are both high, and SHALL be written to the FIFO tail.
REQ-013 tx_ready SHALL be high exactly when the FIFO is not full; a push attempted while tx_ready is low SHALL be ignored with no state change.
REQ-014 The FIFO SHALL use wrap-around read and write pointers plus an occupancy count; a simultaneous push and pop SHALL leave the count unchanged.
REQ-015 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-016 IDLE: tx=1; when the FIFO is non-empty, pop the head into a shift register, clear the bit counter and bit index, and go to START.
REQ-017 START: tx=0 for exactly CLKS_PER_BIT clocks, then go to DATA.
REQ-018 DATA: send 8 bits LSB first, each for exactly CLKS_PER_BIT clocks; after bit 7, go to STOP.
REQ-019 STOP: tx=1 for exactly CLKS_PER_BIT clocks. On the final clock, if the FIFO is non-empty, pop and go to START directly with no idle gap; otherwise go to IDLE.
REQ-020 The frame SHALL be 10 bits, i.e. 10*CLKS_PER_BIT clocks (160 at defaults); back-to-back frames SHALL repeat with exactly that period.
REQ-021 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0; the bit index SHALL be 3 bits.
REQ-022 The tx register SHALL be loaded from the FSM state on each edge. Latency: with the FSM in IDLE and the FIFO empty, a byte accepted at edge k pops at edge k+1, and tx falls at edge k+2.
REQ-023 tx_busy SHALL be high when the state is not IDLE or the FIFO count is non-zero.
REQ-024 The data byte SHALL be captured at pop; tx_data changes after acceptance SHALL not affect frames.
REQ-025 tx SHALL never glitch: it changes only at bit boundaries, or on reset.

Reset
REQ-026 On assertion of rst_n=0, immediately and asynchronously: tx=1, state=IDLE, FIFO pointers and count=0, counters=0, tx_ready=1, tx_busy=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame and discard all buffered bytes; tx SHALL be 1 with no partial stop bit.
REQ-028 After deassertion, the first accepted byte SHALL follow the REQ-022 latency.

Verification
REQ-029 Send a single byte 0xA5 at defaults. Required on tx, each level held 16 clocks: 0, then 1,0,1,0,0,1,0,1, then 1. tx_busy SHALL fall 160 clocks after the start bit begins.
REQ-030 Hold tx_valid high for 6 consecutive bytes 0x00..0x05. Bytes 0..4 SHALL be accepted on 5 consecutive edges and tx_ready SHALL then go low. Byte 5 SHALL be accepted one edge after the second pop, which occurs 160 clocks after the first pop. Six frames SHALL follow, 160 clocks apart with no gaps.
REQ-031 Drive tx_valid while tx_ready=0 with byte 0xFF. The byte SHALL NOT be transmitted, and the FIFO count SHALL be unchanged.
REQ-032 Assert rst_n=0 during bit 3 of frame 0x3C with 2 bytes queued. tx SHALL be 1 in the same cycle, and tx_ready=1, tx_busy=0. No further frames SHALL appear after release until a new push.
REQ-033 Send bytes 0x00 then 0xFF. Required: start bit, 8 zero bits, stop bit, start bit, 8 one bits, stop bit. This is a continuous 320-clock sequence, and tx SHALL return to idle high after it.
REQ-034 Override BAUD_RATE to 2500000 (CLKS_PER_BIT=4) and send 0x81. Every bit SHALL last 4 clocks and the frame SHALL last 40 clocks.
